// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  mole_pkg
//  Shared types and widths for the whack-a-mole sequencing logic.
//  Revision: 1.0
// ============================================================================
package mole_pkg;

   localparam int HOLE_IDX_W  = 4;
   localparam int SCORE_W     = 8;
   localparam int FRAME_CNT_W = 8;
   localparam int GAME_CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PICK = 3'd1,
      UP   = 3'd2,
      DOWN = 3'd3,
      OVER = 3'd4
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
//  mole_lfsr
//  16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps every clock.
//  SEED must be non-zero or the register locks up at zero.
//  Revision: 1.0
// ============================================================================
module mole_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        pclk,
   input  logic        rst,
   output logic [15:0] lfsr
);

   // Right-shifting Galois form: feedback bit 0 is XORed into the tap positions.
   localparam logic [15:0] TAPS = 16'hB400;

   // Free-running shift register, restarts from SEED on reset.
   always_ff @(posedge pclk) begin
      if (rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
//  mole_scheduler
//  Chooses which hole shows a mole and for how many frames, scores hits,
//  counts expired moles and ends the round after a fixed frame budget.
//  Optional feature macro: MOLE_SCHEDULER_SPEEDUP_EN (shrinking up time).
//  Revision: 1.0
// ============================================================================
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int          HOLES         = 9,
   parameter int          UP_FRAMES     = 60,
   parameter int          DOWN_FRAMES   = 30,
   parameter int          GAME_FRAMES   = 1800,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          MIN_UP_FRAMES = 15,
   parameter int          SPEED_STEP    = 5
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  vsync_in,
   input  logic                  start,
   input  logic                  hit_valid,
   input  logic [HOLE_IDX_W-1:0] hit_hole,
   output logic [HOLES-1:0]      mole_mask,
   output logic [SCORE_W-1:0]    score,
   output logic [SCORE_W-1:0]    misses,
   output logic                  busy,
   output logic                  game_over
);

   localparam logic [FRAME_CNT_W-1:0] UP_LOAD   = FRAME_CNT_W'(UP_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] DOWN_LOAD = FRAME_CNT_W'(DOWN_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] CNT_ONE   = FRAME_CNT_W'(1);
   localparam logic [GAME_CNT_W-1:0]  GAME_LAST = GAME_CNT_W'(GAME_FRAMES - 1);
   localparam logic [7:0]             HOLES_8   = 8'(HOLES);
   localparam logic [HOLE_IDX_W-1:0]  LAST_HOLE = HOLE_IDX_W'(HOLES - 1);
   localparam logic [HOLES-1:0]       MASK_ONE  = HOLES'(1);

   state_t                  state, state_n;
   logic                    vs_q;
   logic                    tick;
   logic [15:0]             lfsr;
   logic [7:0]              cand_full;
   logic [HOLE_IDX_W-1:0]   cand, pick;
   logic [HOLE_IDX_W-1:0]   hole, hole_n;
   logic                    have_prev, have_prev_n;
   // One counter serves both the up and the down phase; they never overlap.
   logic [FRAME_CNT_W-1:0]  frame_cnt, frame_cnt_n;
   logic [FRAME_CNT_W-1:0]  up_load;
   logic [GAME_CNT_W-1:0]   game_cnt, game_cnt_n;
   logic [SCORE_W-1:0]      score_n, misses_n;
   logic [HOLES-1:0]        mask_n;
   logic                    in_round, round_end, hit_ok;
   logic                    unused_bits;

   mole_lfsr #(.SEED(SEED)) u_lfsr (
      .pclk (pclk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign tick      = vsync_in & ~vs_q;
   assign cand_full = lfsr[7:0] % HOLES_8;
   assign cand      = cand_full[HOLE_IDX_W-1:0];
   // Never show the mole twice in a row on the same hole.
   assign pick      = (have_prev && (cand == hole)) ?
                      ((cand == LAST_HOLE) ? '0 : cand + 1'b1) : cand;
   assign in_round  = (state == PICK) || (state == UP) || (state == DOWN);
   assign round_end = in_round && tick && (game_cnt == GAME_LAST);
   // hole is always < HOLES, so out-of-range indices can never match.
   assign hit_ok    = hit_valid && (hit_hole == hole);

`ifdef MOLE_SCHEDULER_SPEEDUP_EN
   localparam logic [FRAME_CNT_W-1:0] MIN_LEN  = FRAME_CNT_W'(MIN_UP_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] STEP_LEN = FRAME_CNT_W'(SPEED_STEP);

   logic [FRAME_CNT_W-1:0] up_len, up_len_n, up_len_dec;

   // Shorter up time, never below the floor; extra bit avoids overflow in the sum.
   assign up_len_dec = ({1'b0, up_len} >= ({1'b0, MIN_LEN} + {1'b0, STEP_LEN})) ?
                       (up_len - STEP_LEN) : MIN_LEN;
   assign up_load    = up_len;

   // Current up time, reloaded at the start of every round.
   always_ff @(posedge pclk) begin
      if (rst) begin
         up_len <= '0;
      end else begin
         up_len <= up_len_n;
      end
   end

   assign unused_bits = ^{lfsr[15:8], cand_full[7:HOLE_IDX_W]};
`else
   assign up_load     = UP_LOAD;
   assign unused_bits = ^{lfsr[15:8], cand_full[7:HOLE_IDX_W],
                          8'(MIN_UP_FRAMES), 8'(SPEED_STEP)};
`endif

   // Next-state and datapath decisions; round end overrides everything else.
   always_comb begin
      state_n     = state;
      hole_n      = hole;
      have_prev_n = have_prev;
      frame_cnt_n = frame_cnt;
      game_cnt_n  = game_cnt;
      score_n     = score;
      misses_n    = misses;
`ifdef MOLE_SCHEDULER_SPEEDUP_EN
      up_len_n    = up_len;
`endif

      if (in_round && tick) begin
         game_cnt_n = game_cnt + 1'b1;
      end

      case (state)
         IDLE, OVER: begin
            if (start) begin
               state_n     = PICK;
               score_n     = '0;
               misses_n    = '0;
               game_cnt_n  = '0;
               have_prev_n = 1'b0;
`ifdef MOLE_SCHEDULER_SPEEDUP_EN
               up_len_n    = UP_LOAD;
`endif
            end
         end
         PICK: begin
            hole_n      = pick;
            have_prev_n = 1'b1;
            frame_cnt_n = up_load;
            state_n     = UP;
         end
         UP: begin
            if (hit_ok) begin
               score_n     = sat_inc(score);
               frame_cnt_n = DOWN_LOAD;
               state_n     = DOWN;
`ifdef MOLE_SCHEDULER_SPEEDUP_EN
               if (score_n[2:0] == 3'b000) begin
                  up_len_n = up_len_dec;
               end
`endif
            end else if (tick) begin
               if (frame_cnt <= CNT_ONE) begin
                  misses_n    = sat_inc(misses);
                  frame_cnt_n = DOWN_LOAD;
                  state_n     = DOWN;
               end else begin
                  frame_cnt_n = frame_cnt - 1'b1;
               end
            end
         end
         DOWN: begin
            if (tick) begin
               if (frame_cnt <= CNT_ONE) begin
                  frame_cnt_n = '0;
                  state_n     = PICK;
               end else begin
                  frame_cnt_n = frame_cnt - 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (round_end) begin
         state_n     = OVER;
         hole_n      = hole;
         have_prev_n = have_prev;
         frame_cnt_n = frame_cnt;
         score_n     = score;
         misses_n    = misses;
`ifdef MOLE_SCHEDULER_SPEEDUP_EN
         up_len_n    = up_len;
`endif
      end

      mask_n = (state_n == UP) ? (MASK_ONE << hole_n) : '0;
   end

   // State, counters and registered outputs derived from the state being entered.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state     <= IDLE;
         vs_q      <= 1'b0;
         hole      <= '0;
         have_prev <= 1'b0;
         frame_cnt <= '0;
         game_cnt  <= '0;
         score     <= '0;
         misses    <= '0;
         mole_mask <= '0;
         busy      <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         vs_q      <= vsync_in;
         hole      <= hole_n;
         have_prev <= have_prev_n;
         frame_cnt <= frame_cnt_n;
         game_cnt  <= game_cnt_n;
         score     <= score_n;
         misses    <= misses_n;
         mole_mask <= mask_n;
         busy      <= (state_n == PICK) || (state_n == UP) || (state_n == DOWN);
         game_over <= (state_n == OVER);
      end
   end

endmodule
`default_nettype wire

// File: doc/mole_scheduler.md
# mole_scheduler

Game-sequencing controller for the whack-a-mole display pipeline. It decides which of the nine holes shows a mole, and for how many frames. It scores hits reported by the pointer logic and ends the round after a fixed frame budget. It runs in the pixel clock domain. Its `mole_mask` output drives the per-hole mole/empty selection of the hole-drawing stages.

## Interface
Parameters:
- `HOLES`, 9: number of holes; index range 0..HOLES-1; legal 2..15.
- `UP_FRAMES`, 60: frames a mole stays up.
- `DOWN_FRAMES`, 30: frames with no mole between appearances.
- `GAME_FRAMES`, 1800: round length in frames.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `MIN_UP_FRAMES`, 15: floor for the up time (speed-up only).
- `SPEED_STEP`, 5: up-time decrement per step (speed-up only).

Ports:
- `pclk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `vsync_in`, in, 1: timing-chain vsync; its rising edge is the frame tick.
- `start`, in, 1: one-cycle pulse; starts or restarts a round from IDLE or OVER.
- `hit_valid`, in, 1: one-cycle pulse, a click landed on a hole.
- `hit_hole`, in, 4: hole index of the click; qualified by `hit_valid`.
- `mole_mask`, out, HOLES: one-hot active hole, or all zero; registered.
- `score`, out, 8: hits this round; saturates at 255.
- `misses`, out, 8: expired moles this round; saturates at 255.
- `busy`, out, 1: high in PICK, UP and DOWN.
- `game_over`, out, 1: high in OVER.

## Operation
- **Frame tick:** `vsync_in` is registered into `vs_q`. `tick = vsync_in & ~vs_q`. All frame counters advance only on `tick`.
- **LFSR:** a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every `pclk` cycle from reset, in every state.
- **IDLE:** `mole_mask`=0. On `start`: clear `score`, `misses` and the game counter, then go to PICK.
- **PICK** (one cycle):
  - `cand = lfsr[7:0] mod HOLES`.
  - If `cand` equals the previous hole, use `(cand+1) mod HOLES` instead.
  - Store the result as the current hole, load the up counter, go to UP.
  - The first PICK after `start` has no previous hole.
- **UP:** `mole_mask` is one-hot on the current hole.
  - If `hit_valid` and `hit_hole` equals the current hole: `score`+1, load the down counter with DOWN_FRAMES, go to DOWN.
  - A hit on any other hole, or with `hit_hole >= HOLES`, is ignored.
  - On `tick`: the up counter decrements. If it reaches 0: `misses`+1, load DOWN_FRAMES, go to DOWN.
  - A matching hit and an expiring tick in the same cycle count as a hit only.
- **DOWN:** `mole_mask`=0. On `tick` the counter decrements; when it reaches 0, go to PICK. Hits are ignored.
- **Game counter:** counts ticks while `busy`. On the tick that brings it to GAME_FRAMES, go to OVER from any busy state.
  - This has priority over every other transition in that cycle.
  - A hit in the same cycle is not scored.
- **OVER:** `mole_mask`=0; `score` and `misses` hold. `start` behaves as in IDLE.
- `start` while `busy` is ignored.
- `tick` in IDLE or OVER has no effect.
- **Counter widths:**
  - up and down counters: 8 bits;
  - game counter: 16 bits.
  - Parameters are sized accordingly (UP_FRAMES and DOWN_FRAMES ≤255, GAME_FRAMES ≤65535).

## Timing
- Reset values: `mole_mask`=0, `score`=0, `misses`=0, `busy`=0, `game_over`=0, state IDLE, LFSR=SEED, `vs_q`=0, all counters 0.
- Every output is registered and reflects the state entered at the previous edge.
- `start` at cycle n: PICK at n+1, UP at n+2; `mole_mask` is non-zero from n+2 and `busy`=1 from n+1.
- Matching hit at cycle n: `score` is updated and `mole_mask`=0 at n+1.
- Tick latency: the vsync rising edge is sampled at cycle n; the tick acts at n; counter and outputs change at n+1.
- The mole is up for exactly UP_FRAMES ticks and down for exactly DOWN_FRAMES ticks.
- `rst` high mid-round: all registers take reset values at the next edge. A new `start` is needed afterwards.

## Configuration
`MOLE_SCHEDULER_SPEEDUP_EN`:
- **Defined:** an 8-bit `up_len` register loads UP_FRAMES on `start`. After every hit that makes `score[2:0]` equal 0, `up_len` decreases by SPEED_STEP, clamped at MIN_UP_FRAMES. PICK loads the up counter from `up_len`.
- **Undefined:** the up counter always loads UP_FRAMES; MIN_UP_FRAMES and SPEED_STEP are unused and no `up_len` register exists.

## Structure
- **Shared package `mole_pkg`:**
  - state enum (IDLE, PICK, UP, DOWN, OVER);
  - `HOLE_IDX_W`=4;
  - `SCORE_W`=8;
  - `FRAME_CNT_W`=8;
  - `GAME_CNT_W`=16.
- **Sub-module `mole_lfsr`:** 16-bit Galois LFSR with SEED parameter and `pclk`/`rst` ports. It is reused by the random-colour stages.

## Test plan
- **Miss and re-pick:** UP_FRAMES=4, DOWN_FRAMES=2, reset then `start` → `mole_mask` one-hot 2 cycles after `start`. After 4 vsync rises with no hit: `mole_mask`=0, `misses`=1. After 2 more: a new one-hot mask on a different hole.
- **Correct hit:** `hit_valid` with `hit_hole` equal to the active index during UP → next cycle `score`=1, `mole_mask`=0, `misses`=0.
- **Ignored hits:** `hit_hole` = a wrong index, then 9, then 15, during UP → `score` stays 0 and the mask is unchanged.
- **Hit on expiry:** matching hit in the same cycle as the expiring tick → `score`=1, `misses`=0.
- **Round end and restart:** GAME_FRAMES=10 → on the 10th tick `game_over`=1, `busy`=0, `mole_mask`=0. A hit in that cycle is not scored. `start` → `score`=0, `game_over`=0, PICK entered.
- **Reset mid-round:** `rst` during UP → next cycle all outputs are 0; a later `tick` without `start` keeps the block in IDLE. With `MOLE_SCHEDULER_SPEEDUP_EN`, UP_FRAMES=20, SPEED_STEP=5 → after 8 hits the up time is 15 ticks.
